inst_fetch: RTL
===============

# inst_fetch

Instruction fetch unit: the read-side initiator for the instruction ROM (7-bit address in, 8-bit instruction out, combinational read). It owns the program counter, drives the ROM address and registers each returned instruction into a one-entry output stage. That stage delivers instructions to the decoder over a valid/ready handshake, handling stalls, branch redirects and halt.

## Interface
- ADDR_W, 7, PC/ROM address width
- DATA_W, 8, instruction width
- START_ADDR, 7'h00, PC value on reset and on start_i
- HALT_OPCODE, 8'hFF, instruction that ends fetching

- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse; begin fetching at START_ADDR (honoured in IDLE/HALT only)
- address_o  out  ADDR_W  ROM address, equals PC register (combinational from pc)
- data_i  in  DATA_W  ROM read data, valid same cycle as address_o
- inst_o  out  DATA_W  registered instruction
- inst_pc_o  out  ADDR_W  address inst_o was fetched from
- inst_valid_o  out  1  inst_o holds an undelivered instruction
- inst_ready_i  in  1  decoder accepts inst_o this cycle
- branch_valid_i  in  1  redirect request
- branch_abs_i  in  1  1: target = branch_addr_i; 0: target = inst_pc_o + branch_addr_i (signed, mod 2^ADDR_W)
- branch_addr_i  in  ADDR_W  absolute target or two's-complement offset
- halted_o  out  1  high in HALT state

## Operation
- States: IDLE, FETCH, HALT_PEND, HALT.
- Reset (async, any time incl. mid-fetch): state IDLE, pc=START_ADDR, inst_o=0, inst_pc_o=0, inst_valid_o=0, halted_o=0.
- IDLE: no capture. start_i -> FETCH, pc=START_ADDR.
- FETCH, per cycle, priority order:
  1. branch_valid_i: pc<=target, inst_valid_o<=0 (held instruction discarded, even if inst_ready_i high), no capture this cycle.
  2. slot free (inst_valid_o=0 or inst_ready_i=1): inst_o<=data_i, inst_pc_o<=pc, inst_valid_o<=1, pc<=pc+1 (127 wraps to 0). If data_i==HALT_OPCODE -> HALT_PEND, pc not incremented.
  3. else (stall): all registers hold; address_o stays stable.
- HALT_PEND: no capture. When halt instruction consumed (inst_valid_o & inst_ready_i) -> HALT, inst_valid_o<=0, halted_o<=1. branch_valid_i here (same priority as FETCH) discards the halt, redirects pc, -> FETCH.
- HALT: halted_o=1, inst_valid_o=0. branch_valid_i ignored. start_i -> FETCH, pc=START_ADDR, halted_o<=0.
- Relative target computed with ADDR_W-bit wrap arithmetic; carry discarded.
- inst_o/inst_pc_o never change while inst_valid_o=1 and inst_ready_i=0, except on branch flush or reset.
- start_i in FETCH/HALT_PEND ignored.

## Timing
- start_i sampled at edge N -> FETCH from N; inst_valid_o=1 with inst at START_ADDR after edge N+1.
- Fetch latency: 1 cycle from address_o to inst_o. Throughput 1 instruction/cycle with inst_ready_i held high.
- Branch sampled at edge N: inst_valid_o=0 after N, address_o=target after N, target instruction valid after N+1 (1-cycle bubble).
- Branch and inst_ready_i same cycle: branch wins; consumed instruction still counts as delivered by decoder, no new capture.
- Halt consumed at edge N: halted_o=1 after N.

## Test plan
- Reset: hold rst_n_i=0 mid-FETCH asynchronously -> all outputs go to reset values immediately (address_o=0, inst_valid_o=0, halted_o=0) without waiting for a clock.
- Streaming: ROM[n]=n+1, start_i, inst_ready_i=1 -> consecutive cycles deliver (inst_pc_o,inst_o)=(0,1),(1,2),(2,3)…; address wraps 127->0 after 128 fetches with no gap.
- Stall: inst_ready_i=0 for 3 cycles while holding pc 5 -> inst_o=ROM[5], inst_pc_o=5, address_o=6 stable; release -> next delivered is pc 6, none dropped or duplicated.
- Branch: absolute to 7'h40 while inst_pc_o=3 -> one bubble, then inst_pc_o=0x40; relative offset 7'h7E (-2) with inst_pc_o=1 -> next inst_pc_o=0x7F.
- Halt: ROM[4]=8'hFF -> delivered at pc 4, no fetch of pc 5 captured, halted_o=1 one cycle after consumption; branch in HALT ignored; start_i restarts at pc 0.
- Branch during HALT_PEND with inst_ready_i=0 -> halt flushed, halted_o stays 0, fetch resumes at target.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// inst_fetch: program counter plus a one-entry registered output stage that feeds the
// instruction ROM stream to the decoder. It handles stalls, branch redirects and halt.
module inst_fetch #(
    parameter int              ADDR_W      = 7,
    parameter int              DATA_W      = 8,
    parameter logic [ADDR_W-1:0] START_ADDR  = 7'h00,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] address_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              branch_valid_i,
    input  logic              branch_abs_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              halted_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] FETCH     = 2'd1;
    localparam logic [1:0] HALT_PEND = 2'd2;
    localparam logic [1:0] HALT      = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              slot_free;
    logic              delivered;

    // Relative targets are taken from the instruction being branched from and wrap mod 2^ADDR_W.
    assign target    = branch_abs_i ? branch_addr_i : inst_pc_o + branch_addr_i;
    assign slot_free = !inst_valid_o || inst_ready_i;
    assign delivered = inst_valid_o && inst_ready_i;
    assign address_o = pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            pc           <= START_ADDR;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            halted_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= FETCH;
                        pc    <= START_ADDR;
                    end
                end
                FETCH: begin
                    if (branch_valid_i) begin
                        pc           <= target;
                        inst_valid_o <= 1'b0;
                    end else if (slot_free) begin
                        inst_o       <= data_i;
                        inst_pc_o    <= pc;
                        inst_valid_o <= 1'b1;
                        // The PC parks on the halt so address_o keeps pointing at it.
                        if (data_i == HALT_OPCODE) begin
                            state <= HALT_PEND;
                        end else begin
                            pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                HALT_PEND: begin
                    if (branch_valid_i) begin
                        pc           <= target;
                        inst_valid_o <= 1'b0;
                        state        <= FETCH;
                    end else if (delivered) begin
                        inst_valid_o <= 1'b0;
                        halted_o     <= 1'b1;
                        state        <= HALT;
                    end
                end
                HALT: begin
                    if (start_i) begin
                        state    <= FETCH;
                        pc       <= START_ADDR;
                        halted_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
